// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Holds the controller states, the recode operations and the operand-extension rule.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    NOP,
    ADD1,
    ADD2,
    SUB1,
    SUB2
  } recode_op_e;

  // Bit used to extend an operand: its MSB in signed mode, zero otherwise.
  function automatic logic ext_bit(input logic i_msb, input logic i_signed);
    return i_msb & i_signed;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: maps {Q[1],Q[0],q_m1} to an operation and its addend.
// The radix-2 build feeds Q[0] twice, which collapses the table to 0/+M/-M.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int A_W = 18
) (
  input  logic [2:0]     i_trip,
  input  logic [A_W-1:0] i_m,
  output recode_op_e     o_op,
  output logic [A_W-1:0] o_addend
);

  logic [A_W-1:0] w_m2;

  assign w_m2 = {i_m[A_W-2:0], 1'b0};

  always_comb begin
    o_op = NOP;
    unique case (i_trip)
      3'b001, 3'b010: o_op = ADD1;
      3'b011:         o_op = ADD2;
      3'b100:         o_op = SUB2;
      3'b101, 3'b110: o_op = SUB1;
      default:        o_op = NOP;
    endcase
  end

  always_comb begin
    o_addend = '0;
    case (o_op)
      ADD1:    o_addend = i_m;
      ADD2:    o_addend = w_m2;
      SUB1:    o_addend = -i_m;
      SUB2:    o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with start/busy/done handshake, signed or unsigned per operation.
// Define BOOTH_RADIX4_EN for radix-4 recoding (two bits per iteration); default is radix-2.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 2) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
  localparam int E_W   = ((WIDTH + 1) % 2 == 0) ? (WIDTH + 1) : (WIDTH + 2);
  localparam int A_W   = E_W + 1;
  localparam int SHIFT = 2;
`else
  localparam int E_W   = WIDTH + 1;
  localparam int A_W   = E_W;
  localparam int SHIFT = 1;
`endif
  localparam int ITER  = E_W / SHIFT;
  localparam int CAT_W = A_W + E_W + 1;
  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [A_W-1:0]          r_m;
  logic signed [A_W-1:0]   r_a;
  logic [E_W-1:0]          r_q;
  logic                    r_q_m1;
  logic [CNT_W-1:0]        r_count;
  logic [2*WIDTH-1:0]      r_product;

  logic                    w_accept;
  logic                    w_last;
  logic [2:0]              w_trip;
  recode_op_e              w_op;
  logic [A_W-1:0]          w_addend;
  logic [A_W-1:0]          w_sum;
  logic signed [CAT_W-1:0] w_cat;
  logic signed [CAT_W-1:0] w_shift;
  logic                    w_m_ext;
  logic                    w_q_ext;

`ifdef BOOTH_RADIX4_EN
  assign w_trip = {r_q[1], r_q[0], r_q_m1};
`else
  assign w_trip = {r_q[0], r_q[0], r_q_m1};
`endif

  booth_recoder #(
    .A_W (A_W)
  ) u_recoder (
    .i_trip   (w_trip),
    .i_m      (r_m),
    .o_op     (w_op),
    .o_addend (w_addend)
  );

  assign w_m_ext = ext_bit(multiplicand[WIDTH-1], signed_mode);
  assign w_q_ext = ext_bit(multiplier[WIDTH-1], signed_mode);

  // Add/sub wraps in A_W bits; the shift replicates A's MSB into the vacated bits.
  assign w_sum   = (w_op == NOP) ? r_a : (r_a + w_addend);
  assign w_cat   = {w_sum, r_q, r_q_m1};
  assign w_shift = w_cat >>> SHIFT;

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == CNT_W'(1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_m     <= {{(A_W - WIDTH){w_m_ext}}, multiplicand};
        r_q     <= {{(E_W - WIDTH){w_q_ext}}, multiplier};
        r_a     <= '0;
        r_q_m1  <= 1'b0;
        r_count <= ITER_C;
      end else if (r_state == CALC) begin
        r_a     <= w_shift[CAT_W-1 -: A_W];
        r_q     <= w_shift[E_W:1];
        r_q_m1  <= w_shift[0];
        r_count <= r_count - CNT_W'(1);
        // The full product occupies {A,Q}; the low 2*WIDTH bits are exact.
        if (w_last) begin
          r_product <= w_shift[2*WIDTH:1];
        end
      end
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=16): directed cases, handshake, reset abort, random.
// Expected products go into a queue when an operation is launched and are popped at done.
module tb_booth_mult_seq;

  localparam int WIDTH = 16;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif
  localparam int LIMIT = 100;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int tests  = 0;
  int failed = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  booth_mult_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = s ? {{16{a[15]}}, a} : {16'h0, a};
    eb = s ? {{16{b[15]}}, b} : {16'h0, b};
    return ea * eb;
  endfunction

  task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
    @(negedge clk);
    start        = 1'b1;
    signed_mode  = s;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests++;
    if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b, expected 0", done); end
    tests++;
    if (product !== 32'h0) begin failed++; $display("FAIL reset_product: got %h, expected 00000000", product); end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic        s_t[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] a_t[5] = '{16'h0003, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic [15:0] b_t[5] = '{16'hFFFB, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic [31:0] p_t[5] = '{32'hFFFFFFF1, 32'h40000000, 32'h40000000, 32'hFFFE0001, 32'h00000001};
    int n;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      start_op(s_t[i], a_t[i], b_t[i], p_t[i]);
      tests++;
      if (busy !== 1'b1) begin failed++; $display("FAIL directed_busy[%0d]: got %b, expected 1", i, busy); end
      wait_done(n);
      tests++;
      if (n !== LAT) begin failed++; $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, n, LAT); end
      tests++;
      if (exp_q.size() == 0) begin
        failed++; $display("FAIL directed_scoreboard[%0d]: got empty queue, expected one entry", i);
      end else begin
        exp = exp_q.pop_front();
        if (product !== exp) begin failed++; $display("FAIL directed_product[%0d]: got %h, expected %h", i, product, exp); end
      end
      $display("[TB] directed s=%0d %h x %h -> %h after %0d cycles", s_t[i], a_t[i], b_t[i], product, n);
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failed++; $display("FAIL directed_pulse[%0d]: got done=%b busy=%b, expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, t_first, pulses;
    logic [31:0] exp;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; multiplicand = 16'h0123; multiplier = 16'hFF00;
    exp_q.push_back(ref_mul(1'b1, 16'h0123, 16'hFF00));
    t = 0; pulses = 0; t_first = 0;
    while (pulses < 2 && t < 4 * LAT) begin
      @(negedge clk);
      t++;
      if (t == 5) begin
        signed_mode = 1'b0; multiplicand = 16'h7FFF; multiplier = 16'h8001;
        exp_q.push_back(ref_mul(1'b0, 16'h7FFF, 16'h8001));
      end
      if (done === 1'b1) begin
        pulses++;
        tests++;
        if (exp_q.size() == 0) begin
          failed++; $display("FAIL b2b_scoreboard: got empty queue, expected one entry");
        end else begin
          exp = exp_q.pop_front();
          if (product !== exp) begin failed++; $display("FAIL b2b_product[%0d]: got %h, expected %h", pulses, product, exp); end
        end
        $display("[TB] back-to-back pulse %0d at cycle %0d -> %h", pulses, t, product);
        if (pulses == 1) begin
          t_first = t;
        end else begin
          start = 1'b0;
          tests++;
          if (t - t_first !== LAT + 2) begin
            failed++; $display("FAIL b2b_spacing: got %0d, expected %0d", t - t_first, LAT + 2);
          end
        end
      end
    end
    start = 1'b0;
    tests++;
    if (pulses !== 2) begin failed++; $display("FAIL b2b_pulses: got %0d, expected 2", pulses); end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL b2b_idle: got busy=%b, expected 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_done;
    logic [31:0] exp;
    start_op(1'b1, 16'h1234, 16'hF00D, ref_mul(1'b1, 16'h1234, 16'hF00D));
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    tests++;
    if (product !== 32'h0) begin failed++; $display("FAIL abort_product: got %h, expected 00000000", product); end
    saw_done = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin failed++; $display("FAIL abort_no_done: got %b, expected 0", saw_done); end
    $display("[TB] reset abort mid-operation");
    start_op(1'b0, 16'hBEEF, 16'h0042, ref_mul(1'b0, 16'hBEEF, 16'h0042));
    wait_done(n);
    tests++;
    if (n !== LAT) begin failed++; $display("FAIL abort_restart_latency: got %0d, expected %0d", n, LAT); end
    tests++;
    if (exp_q.size() == 0) begin
      failed++; $display("FAIL abort_restart_scoreboard: got empty queue, expected one entry");
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp) begin failed++; $display("FAIL abort_restart_product: got %h, expected %h", product, exp); end
    end
    $display("[TB] restart after abort -> %h", product);
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    logic s;
    logic [15:0] a, b;
    logic [31:0] exp;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      start_op(s, a, b, ref_mul(s, a, b));
      wait_done(n);
      tests++;
      if (n !== LAT) begin failed++; $display("FAIL random_latency[%0d]: got %0d, expected %0d", i, n, LAT); end
      tests++;
      if (exp_q.size() == 0) begin
        failed++; $display("FAIL random_scoreboard[%0d]: got empty queue, expected one entry", i);
      end else begin
        exp = exp_q.pop_front();
        if (product !== exp) begin failed++; $display("FAIL random_product[%0d]: got %h, expected %h", i, product, exp); end
      end
      $display("[TB] random %0d s=%0d %h x %h -> %h", i, s, a, b, product);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
